// File: rtl/count_bus_host_if.sv
// count_bus_host_if: command/response handshake plus the host side of the
// counter tile's load/readback bus.
//   cmd_valid/cmd_ready/cmd_write/cmd_data  command channel (source -> host)
//   rsp_valid/rsp_ready/rsp_data/rsp_err    response channel (host -> consumer)
//   bus_in/bus_out/bus_oe                   8-bit bidirectional bus, split form
//   peer_load/peer_oe                       tile ui_in[0]/ui_in[1]
// Modports: slave = count_bus_host itself; master = command source and peer.
interface count_bus_host_if #(
   parameter int unsigned DW = 8
) ();
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [DW-1:0] cmd_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic [DW-1:0] bus_in;
   logic [DW-1:0] bus_out;
   logic [DW-1:0] bus_oe;
   logic          peer_load;
   logic          peer_oe;

   modport slave (
      input  cmd_valid, cmd_write, cmd_data, rsp_ready, bus_in,
      output cmd_ready, rsp_valid, rsp_data, rsp_err, bus_out, bus_oe, peer_load, peer_oe
   );

   modport master (
      output cmd_valid, cmd_write, cmd_data, rsp_ready, bus_in,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err, bus_out, bus_oe, peer_load, peer_oe
   );
endinterface

// File: rtl/count_bus_host.sv
// count_bus_host: turns single-word write/read commands into the counter
// tile's pin protocol (peer_load + driven data for a write, peer_oe with the
// host released for a read) and owns bus turnaround.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    count_bus_host_if.slave: command, response, bus and peer pins
// Parameters:
//   DW     bus/counter width
//   TURN   idle RD cycles after peer_oe rises before sampling (0..7)
// Optional feature: define COUNT_BUS_HOST_CHECK_EN to keep a shadow copy of
// the peer counter and flag rsp_err when a readback disagrees with it;
// otherwise rsp_err is tied 0.
// All outputs are registered and derived from the next state.
module count_bus_host #(
   parameter int unsigned DW   = 8,
   parameter int unsigned TURN = 1
) (
   input logic              clk,
   input logic              rst_n,
   count_bus_host_if.slave  bus
);

   typedef enum logic [1:0] {
      StIdle,
      StWr,
      StRd,
      StRsp
   } state_e;

   localparam logic [2:0] TurnLast = 3'(TURN);

   state_e        state_q, state_d;
   logic [2:0]    turn_cnt_q, turn_cnt_d;
   logic [DW-1:0] bus_out_q, bus_out_d;
   logic [DW-1:0] rsp_data_q, rsp_data_d;
   logic          rsp_err_q, rsp_err_d;
   logic          cmd_ready_q, cmd_ready_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          bus_oe_q, bus_oe_d;
   logic          peer_load_q, peer_load_d;
   logic          peer_oe_q, peer_oe_d;
   logic          chk_mismatch;

`ifdef COUNT_BUS_HOST_CHECK_EN
   // Mirrors the free-running peer: loads on the same edge the peer does
   // (WR exit, data still held in bus_out_q), otherwise counts every cycle.
   logic [DW-1:0] shadow_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
      end else if (state_q == StWr) begin
         shadow_q <= bus_out_q;
      end else begin
         shadow_q <= shadow_q + DW'(1);
      end
   end

   assign chk_mismatch = (bus.bus_in != shadow_q);
`else
   assign chk_mismatch = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      turn_cnt_d = turn_cnt_q;
      bus_out_d  = bus_out_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;

      unique case (state_q)
         StIdle: begin
            if (bus.cmd_valid) begin
               if (bus.cmd_write) begin
                  state_d   = StWr;
                  bus_out_d = bus.cmd_data;
               end else begin
                  state_d    = StRd;
                  turn_cnt_d = '0;
               end
            end
         end
         StWr: begin
            state_d   = StIdle;
            bus_out_d = '0;
         end
         StRd: begin
            if (turn_cnt_q == TurnLast) begin
               state_d    = StRsp;
               rsp_data_d = bus.bus_in;
               rsp_err_d  = chk_mismatch;
            end else begin
               turn_cnt_d = turn_cnt_q + 3'd1;
            end
         end
         StRsp: begin
            if (bus.rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Registered outputs follow the state being entered. Leaving RD for RSP
      // drops peer_oe, and RSP always lasts a cycle, so a released cycle
      // separates peer drive from any following host drive.
      cmd_ready_d = (state_d == StIdle);
      bus_oe_d    = (state_d == StWr);
      peer_load_d = (state_d == StWr);
      peer_oe_d   = (state_d == StRd);
      rsp_valid_d = (state_d == StRsp);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         turn_cnt_q  <= '0;
         bus_out_q   <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         bus_oe_q    <= 1'b0;
         peer_load_q <= 1'b0;
         peer_oe_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         turn_cnt_q  <= turn_cnt_d;
         bus_out_q   <= bus_out_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         bus_oe_q    <= bus_oe_d;
         peer_load_q <= peer_load_d;
         peer_oe_q   <= peer_oe_d;
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.bus_out   = bus_out_q;
   assign bus.bus_oe    = {DW{bus_oe_q}};
   assign bus.peer_load = peer_load_q;
   assign bus.peer_oe   = peer_oe_q;

endmodule

// File: tb/tb_count_bus_host.sv
// tb_count_bus_host: directed bench for count_bus_host (DW=8, TURN=1) with a
// behavioural free-running counter tile on the peer side and a response
// scoreboard (expected readbacks queued at acceptance, popped on rsp_valid).
module tb_count_bus_host;

   localparam int unsigned DW   = 8;
   localparam int unsigned TURN = 1;

`ifdef COUNT_BUS_HOST_CHECK_EN
   localparam logic ErrOnFlip = 1'b1;
`else
   localparam logic ErrOnFlip = 1'b0;
`endif

   typedef struct packed {
      logic [DW-1:0] data;
      logic          err;
   } exp_t;

   logic clk;
   logic rst_n;
   logic [DW-1:0] peer_cnt;
   logic flip;
   int checks;
   int failures;
   int conflicts;
   exp_t exp_q[$];

   count_bus_host_if #(.DW(DW)) bus_if ();

   count_bus_host #(
      .DW   (DW),
      .TURN (TURN)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counter tile model: free-running, loads bus_out when peer_load is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) peer_cnt <= '0;
      else if (bus_if.peer_load) peer_cnt <= bus_if.bus_out;
      else peer_cnt <= peer_cnt + 8'd1;
   end

   assign bus_if.bus_in = bus_if.peer_oe ? (peer_cnt ^ {7'd0, flip}) : '0;

   // Ownership monitor: host and peer never drive together; bus_oe bits equal.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus_if.peer_oe && (bus_if.bus_oe != '0)) conflicts++;
         if ((bus_if.bus_oe != '0) && (bus_if.bus_oe != '1)) conflicts++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Accept a read on the next edge; queue the readback the tile model will show.
   task automatic accept_read(input string tag, input bit use_model, input logic [DW-1:0] data,
                              input logic err);
      exp_t e;
      check({tag, "_ready"}, 32'(bus_if.cmd_ready), 32'd1);
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_write = 1'b0;
      bus_if.cmd_data  = 8'hA5;
      tick();
      bus_if.cmd_valid = 1'b0;
      check({tag, "_acc_peer_oe"}, 32'(bus_if.peer_oe), 32'd1);
      check({tag, "_acc_busy"}, 32'(bus_if.cmd_ready), 32'd0);
      e.data = use_model ? ((peer_cnt + 8'(TURN)) ^ {7'd0, flip}) : data;
      e.err  = err;
      exp_q.push_back(e);
   endtask

   task automatic wait_rsp(input string tag, output int lat);
      lat = 0;
      while (!bus_if.rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      if (!bus_if.rsp_valid) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout observed=no rsp_valid expected=rsp_valid within 20 cycles",
                  tag);
      end
   endtask

   task automatic pop_rsp(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_sb observed=response expected=empty scoreboard", tag);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_data"}, 32'(bus_if.rsp_data), 32'(e.data));
         check({tag, "_err"}, 32'(bus_if.rsp_err), 32'(e.err));
      end
   endtask

   // Write at E0, read offered during WR so it is accepted at E2.
   task automatic write_then_read(input string tag, input logic [DW-1:0] wdata,
                                  input logic [DW-1:0] rdata);
      int lat;
      check({tag, "_wr_ready"}, 32'(bus_if.cmd_ready), 32'd1);
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_write = 1'b1;
      bus_if.cmd_data  = wdata;
      tick();  // E0
      check({tag, "_wr_load"}, 32'(bus_if.peer_load), 32'd1);
      check({tag, "_wr_oe"}, 32'(bus_if.bus_oe), 32'hFF);
      check({tag, "_wr_out"}, 32'(bus_if.bus_out), 32'(wdata));
      check({tag, "_wr_busy"}, 32'(bus_if.cmd_ready), 32'd0);
      bus_if.cmd_write = 1'b0;
      tick();  // E1: peer loads, WR done
      check({tag, "_load_1cyc"}, 32'(bus_if.peer_load), 32'd0);
      check({tag, "_e1_ready"}, 32'(bus_if.cmd_ready), 32'd1);
      check({tag, "_e1_no_rd"}, 32'(bus_if.peer_oe), 32'd0);
      bus_if.cmd_valid = 1'b0;
      accept_read(tag, 1'b0, rdata, 1'b0);  // E2
      wait_rsp(tag, lat);
      check({tag, "_lat"}, 32'(lat), 32'(TURN + 1));
      pop_rsp(tag);
      tick();
   endtask

   initial begin
      int lat;
      checks    = 0;
      failures  = 0;
      conflicts = 0;
      flip      = 1'b0;
      rst_n     = 1'b0;
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_write = 1'b0;
      bus_if.cmd_data  = '0;
      bus_if.rsp_ready = 1'b1;

      // Reset values
      repeat (3) tick();
      check("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(bus_if.rsp_data), 32'd0);
      check("rst_rsp_err", 32'(bus_if.rsp_err), 32'd0);
      check("rst_bus_out", 32'(bus_if.bus_out), 32'd0);
      check("rst_bus_oe", 32'(bus_if.bus_oe), 32'd0);
      check("rst_peer_load", 32'(bus_if.peer_load), 32'd0);
      check("rst_peer_oe", 32'(bus_if.peer_oe), 32'd0);

      // Read accepted at the 5th edge after release: sample = count after edge 6
      rst_n = 1'b1;
      repeat (4) tick();
      accept_read("rd0", 1'b0, 8'h06, 1'b0);
      wait_rsp("rd0", lat);
      check("rd0_lat", 32'(lat), 32'd2);
      pop_rsp("rd0");
      tick();
      check("rd0_rsp_1cyc", 32'(bus_if.rsp_valid), 32'd0);

      // Write then read: 0x40 loaded at E1, sample at E4 sees 0x42
      write_then_read("wr40", 8'h40, 8'h42);
      // Wrap: 0xFE at E1, 0xFF at E2, 0x00 after E3 sampled at E4
      write_then_read("wrap", 8'hFE, 8'h00);

      // Response back-pressure with a read pending on the command port
      bus_if.rsp_ready = 1'b0;
      accept_read("hold", 1'b1, '0, 1'b0);
      wait_rsp("hold", lat);
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_write = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_valid", 32'(bus_if.rsp_valid), 32'd1);
         check("hold_data", 32'(bus_if.rsp_data), 32'(exp_q[0].data));
         check("hold_busy", 32'(bus_if.cmd_ready), 32'd0);
         check("hold_peer_oe", 32'(bus_if.peer_oe), 32'd0);
         check("hold_bus_oe", 32'(bus_if.bus_oe), 32'd0);
         check("hold_peer_load", 32'(bus_if.peer_load), 32'd0);
      end
      pop_rsp("hold");
      bus_if.rsp_ready = 1'b1;
      tick();  // handshake edge
      check("hs_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      check("hs_ready", 32'(bus_if.cmd_ready), 32'd1);
      tick();  // pending read accepted one cycle later
      bus_if.cmd_valid = 1'b0;
      check("hs_acc_peer_oe", 32'(bus_if.peer_oe), 32'd1);
      exp_q.push_back('{data: peer_cnt + 8'(TURN), err: 1'b0});
      wait_rsp("hs", lat);
      check("hs_lat", 32'(lat), 32'(TURN + 1));
      pop_rsp("hs");
      tick();

      // Reset in the middle of RD discards the read
      accept_read("mid", 1'b0, '0, 1'b0);
      void'(exp_q.pop_back());
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst_peer_oe", 32'(bus_if.peer_oe), 32'd0);
      check("midrst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      check("midrst_ready", 32'(bus_if.cmd_ready), 32'd1);
      check("midrst_bus_oe", 32'(bus_if.bus_oe), 32'd0);
      tick();
      rst_n = 1'b1;
      accept_read("post", 1'b0, 8'h02, 1'b0);  // edge 1 after release; sample = 2
      wait_rsp("post", lat);
      pop_rsp("post");
      tick();

      // Corrupted readback: bit 0 of the peer drive inverted
      flip = 1'b1;
      accept_read("flip", 1'b1, '0, ErrOnFlip);
      wait_rsp("flip", lat);
      flip = 1'b0;
      pop_rsp("flip");
      tick();

      // Clean read afterwards clears the error indication
      accept_read("clean", 1'b1, '0, 1'b0);
      wait_rsp("clean", lat);
      pop_rsp("clean");
      repeat (2) tick();

      check("bus_conflicts", 32'(conflicts), 32'd0);
      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
